pc_increment: RTL and testbench

- Y86-64 fetch-stage helper that computes the fall-through address valP from the current PC and the instruction-format flags.
- Instruction length is 1 byte (icode:ifun), plus 1 byte if a register-specifier byte is present, plus 8 bytes if a constant word is present.
- Provides a zero-latency combinational result for the fetch datapath.
- Also provides a one-stage registered copy with valid/stall handshake for the pipelined fetch register.

---
 rtl/pc_increment_if.sv | 31 +++
 rtl/pc_increment.sv | 74 +++++++
 tb/tb_pc_increment.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pc_increment_if.sv
// Fetch-side bundle for the PC incrementer: request (pc + format flags + handshake)
// and the combinational and registered responses.
interface pc_increment_if #(
  parameter int ADDR_W = 64
);
  // Request
  logic              in_valid;
  logic              stall;
  logic [ADDR_W-1:0] pc;
  logic              need_regids;
  logic              need_valC;
  // Combinational response
  logic [ADDR_W-1:0] valP;
  logic [3:0]        ilen;
  logic              wrap;
  // Registered response
  logic [ADDR_W-1:0] valP_q;
  logic [3:0]        ilen_q;
  logic              wrap_q;
  logic              valid_q;

  modport master (
    output in_valid, stall, pc, need_regids, need_valC,
    input  valP, ilen, wrap, valP_q, ilen_q, wrap_q, valid_q
  );

  modport slave (
    input  in_valid, stall, pc, need_regids, need_valC,
    output valP, ilen, wrap, valP_q, ilen_q, wrap_q, valid_q
  );
endinterface

// File: rtl/pc_increment.sv
// Y86-64 fall-through PC: valP = pc + instruction length, with a zero-latency
// combinational result and a one-stage stallable registered copy.
module pc_increment #(
  parameter int ADDR_W     = 64,
  parameter int VALC_BYTES = 8
) (
  input  logic          clk,
  input  logic          reset,
  pc_increment_if.slave bus
);

  logic [3:0]        ilen;
  logic [ADDR_W:0]   sum;
  logic [ADDR_W-1:0] valP;
  logic              wrap;

  logic [ADDR_W-1:0] valP_q, valP_d;
  logic [3:0]        ilen_q, ilen_d;
  logic              wrap_q, wrap_d;
  logic              valid_q, valid_d;

  // Length is 1 (icode:ifun) + optional rA:rB byte + optional constant word.
  always_comb begin
    ilen = 4'd1;
    if (bus.need_regids) ilen = ilen + 4'd1;
    if (bus.need_valC)   ilen = ilen + 4'(VALC_BYTES);
  end

  // One extra bit on the adder captures the carry-out as the wrap flag.
  assign sum  = {1'b0, bus.pc} + {{(ADDR_W-3){1'b0}}, ilen};
  assign valP = sum[ADDR_W-1:0];
  assign wrap = sum[ADDR_W];

  always_comb begin
    valP_d  = valP_q;
    ilen_d  = ilen_q;
    wrap_d  = wrap_q;
    valid_d = valid_q;
    if (!bus.stall) begin
      if (bus.in_valid) begin
        valP_d  = valP;
        ilen_d  = ilen;
        wrap_d  = wrap;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Reset dominates stall so a held result is always discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      valP_q  <= '0;
      ilen_q  <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valP_q  <= valP_d;
      ilen_q  <= ilen_d;
      wrap_q  <= wrap_d;
      valid_q <= valid_d;
    end
  end

  assign bus.valP    = valP;
  assign bus.ilen    = ilen;
  assign bus.wrap    = wrap;
  assign bus.valP_q  = valP_q;
  assign bus.ilen_q  = ilen_q;
  assign bus.wrap_q  = wrap_q;
  assign bus.valid_q = valid_q;

endmodule

// File: tb/tb_pc_increment.sv
// Randomized bench for pc_increment against an arithmetic reference model.
module tb_pc_increment;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_increment_if #(.ADDR_W(64)) bus ();
  pc_increment #(.ADDR_W(64), .VALC_BYTES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state for the registered stage
  logic [63:0] m_valP_q  = '0;
  logic [3:0]  m_ilen_q  = '0;
  logic        m_wrap_q  = 1'b0;
  logic        m_valid_q = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_len(input logic r, input logic c);
    return 1 + (r ? 1 : 0) + (c ? 8 : 0);
  endfunction

  function automatic logic [64:0] ref_sum(input logic [63:0] p, input logic r, input logic c);
    logic [64:0] s;
    s = {1'b0, p} + 65'(ref_len(r, c));
    return s;
  endfunction

  task automatic check_comb(input string tag);
    logic [64:0] s;
    #1;
    s = ref_sum(bus.pc, bus.need_regids, bus.need_valC);
    chk({tag, "_valP"}, bus.valP, s[63:0]);
    chk({tag, "_ilen"}, 64'(bus.ilen), 64'(ref_len(bus.need_regids, bus.need_valC)));
    chk({tag, "_wrap"}, 64'(bus.wrap), 64'(s[64]));
  endtask

  // Advance the model with the currently driven inputs, clock, then compare.
  task automatic tick(input string tag);
    logic [64:0] s;
    s = ref_sum(bus.pc, bus.need_regids, bus.need_valC);
    if (reset) begin
      m_valP_q = '0; m_ilen_q = '0; m_wrap_q = 1'b0; m_valid_q = 1'b0;
    end else if (!bus.stall) begin
      if (bus.in_valid) begin
        m_valP_q  = s[63:0];
        m_ilen_q  = 4'(ref_len(bus.need_regids, bus.need_valC));
        m_wrap_q  = s[64];
        m_valid_q = 1'b1;
      end else begin
        m_valid_q = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "_valP_q"},  bus.valP_q,          m_valP_q);
    chk({tag, "_ilen_q"},  64'(bus.ilen_q),     64'(m_ilen_q));
    chk({tag, "_wrap_q"},  64'(bus.wrap_q),     64'(m_wrap_q));
    chk({tag, "_valid_q"}, 64'(bus.valid_q),    64'(m_valid_q));
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.stall = 1'b0;
    bus.pc = 64'h38; bus.need_regids = 1'b1; bus.need_valC = 1'b1;

    // Combinational directed cases, spec constants
    #1;
    chk("c11_valP", bus.valP, 64'h42);
    chk("c11_ilen", 64'(bus.ilen), 64'd10);
    chk("c11_wrap", 64'(bus.wrap), 64'd0);
    bus.need_regids = 1'b0; bus.need_valC = 1'b0; #1;
    chk("c00_valP", bus.valP, 64'h39);
    chk("c00_ilen", 64'(bus.ilen), 64'd1);
    bus.need_regids = 1'b1; #1;
    chk("c10_valP", bus.valP, 64'h3A);
    chk("c10_ilen", 64'(bus.ilen), 64'd2);
    bus.need_regids = 1'b0; bus.need_valC = 1'b1; #1;
    chk("c01_valP", bus.valP, 64'h41);
    chk("c01_ilen", 64'(bus.ilen), 64'd9);
    bus.pc = 64'hFFFF_FFFF_FFFF_FFFE; bus.need_regids = 1'b1; #1;
    chk("wrapA_valP", bus.valP, 64'h8);
    chk("wrapA_wrap", 64'(bus.wrap), 64'd1);
    bus.pc = 64'hFFFF_FFFF_FFFF_FFFF; bus.need_regids = 1'b0; bus.need_valC = 1'b0; #1;
    chk("wrapB_valP", bus.valP, 64'h0);
    chk("wrapB_wrap", 64'(bus.wrap), 64'd1);

    // Reset held two edges with in_valid high
    tick("rst0");
    tick("rst1");
    chk("rst_valid_q", 64'(bus.valid_q), 64'd0);

    reset = 1'b0; bus.pc = 64'h100; bus.need_valC = 1'b1;
    tick("load");
    chk("load_valP_q", bus.valP_q, 64'h109);
    chk("load_ilen_q", 64'(bus.ilen_q), 64'd9);
    chk("load_valid_q", 64'(bus.valid_q), 64'd1);

    bus.stall = 1'b1; bus.pc = 64'h200;
    tick("stall");
    chk("stall_hold", bus.valP_q, 64'h109);
    chk("stall_comb", bus.valP, 64'h209);

    bus.stall = 1'b0;
    tick("unstall");
    chk("unstall_valP_q", bus.valP_q, 64'h209);

    bus.in_valid = 1'b0; bus.pc = 64'h300;
    tick("idle");
    chk("idle_valid_q", 64'(bus.valid_q), 64'd0);
    chk("idle_hold", bus.valP_q, 64'h209);

    bus.in_valid = 1'b1;
    tick("reload");
    bus.stall = 1'b1; reset = 1'b1;
    tick("rst_stall");
    chk("rst_stall_valid_q", 64'(bus.valid_q), 64'd0);
    chk("rst_stall_valP_q", bus.valP_q, 64'd0);
    chk("rst_live_comb", bus.valP, 64'h309);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      #2;
      reset           = ($urandom_range(0, 31) == 0);
      bus.stall       = ($urandom_range(0, 3) == 0);
      bus.in_valid    = ($urandom_range(0, 4) != 0);
      bus.need_regids = 1'($urandom);
      bus.need_valC   = 1'($urandom);
      if ($urandom_range(0, 3) == 0)
        bus.pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else
        bus.pc = {$urandom, $urandom};
      check_comb("rnd");
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
